// File: rtl/ring_freq_meter_if.sv
// Result/handshake bundle between the ring frequency meter and its consumer.
interface ring_freq_meter_if #(
   parameter int unsigned pCNT_W = 12
);
   logic              i_start;
   logic              i_cont;
   logic              i_ack;
   logic              o_busy;
   logic              o_valid;
   logic [pCNT_W-1:0] o_count;
   logic              o_ovf;
   logic              o_lost;

   // Consumer side: issues commands, reads results.
   modport master (
      output i_start, i_cont, i_ack,
      input  o_busy, o_valid, o_count, o_ovf, o_lost
   );

   // Meter side.
   modport slave (
      input  i_start, i_cont, i_ack,
      output o_busy, o_valid, o_count, o_ovf, o_lost
   );
endinterface

// File: rtl/ring_freq_meter.sv
// Ring oscillator frequency meter: counts synchronized rising edges of the ring output over a
// 2^pGATE_LOG2-clock gate window and reports the count through a valid/ack result register.
module ring_freq_meter #(
   parameter int unsigned pGATE_LOG2 = 10,
   parameter int unsigned pCNT_W     = 12,
   parameter int unsigned pSETTLE    = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ring,
   ring_freq_meter_if.slave bus
);

   localparam int unsigned SetW = $clog2(pSETTLE + 1);
   localparam logic [SetW-1:0] SetLast = SetW'(pSETTLE - 1);

   typedef enum logic [1:0] {StIdle, StSettle, StMeasure} state_e;

   state_e              state_q, state_d;
   logic                s1_q, s2_q, s3_q;
   logic                rise;
   logic [SetW-1:0]     settle_q;
   logic [pGATE_LOG2-1:0] gate_q;
   logic [pCNT_W-1:0]   edge_q, edge_nxt;
   logic                ovf_q, ovf_nxt;
   logic                start_acc;
   logic                win_end;
   logic [pCNT_W-1:0]   count_q;
   logic                rovf_q;
   logic                valid_q;
   logic                lost_q;

   // Three-flop synchronizer; only the s2/s3 pair is used for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= i_ring;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

   // Saturating edge count including any rise on the current cycle.
   always_comb begin
      edge_nxt = edge_q;
      ovf_nxt  = ovf_q;
      if (rise) begin
         if (&edge_q) begin
            ovf_nxt = 1'b1;
         end else begin
            edge_nxt = edge_q + 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and control strobes.
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      win_end   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.i_start) begin
               state_d   = StSettle;
               start_acc = 1'b1;
            end
         end
         StSettle: begin
            if (settle_q == SetLast) begin
               state_d = StMeasure;
            end
         end
         StMeasure: begin
            if (&gate_q) begin
               win_end = 1'b1;
               // i_cont is only looked at here, so dropping it mid-window is harmless.
               if (!bus.i_cont) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Settle, gate and edge counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         settle_q <= '0;
         gate_q   <= '0;
         edge_q   <= '0;
         ovf_q    <= 1'b0;
      end else if (start_acc) begin
         settle_q <= '0;
         gate_q   <= '0;
         edge_q   <= '0;
         ovf_q    <= 1'b0;
      end else if (state_q == StSettle) begin
         settle_q <= settle_q + 1'b1;
      end else if (state_q == StMeasure) begin
         if (win_end) begin
            // Back-to-back windows in continuous mode start from zero with no gap.
            gate_q <= '0;
            edge_q <= '0;
            ovf_q  <= 1'b0;
         end else begin
            gate_q <= gate_q + 1'b1;
            edge_q <= edge_nxt;
            ovf_q  <= ovf_nxt;
         end
      end
   end

   // Result register with valid/ack handshake and sticky lost flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
         rovf_q  <= 1'b0;
         valid_q <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         if (win_end) begin
            count_q <= edge_nxt;
            rovf_q  <= ovf_nxt;
            valid_q <= 1'b1;
            if (valid_q && !bus.i_ack) begin
               lost_q <= 1'b1;
            end
         end else if (bus.i_ack) begin
            valid_q <= 1'b0;
         end
         if (start_acc) begin
            lost_q <= 1'b0;
         end
      end
   end

   assign bus.o_busy  = (state_q != StIdle);
   assign bus.o_valid = valid_q;
   assign bus.o_count = count_q;
   assign bus.o_ovf   = rovf_q;
   assign bus.o_lost  = lost_q;

endmodule
